mvb_frame_tx_seq: RTL

Frame sequencer for the MVB transmit path. It accepts one parallel data word per frame through a valid/ready handshake and serialises it MSB-first at the 1.5 MHz bit rate. It drives the ready/send controls and serial data input of the shared 8-bit CRC unit, then appends the unit's 8 check bits. The result is one aligned serial stream, `tx_o`/`tx_valid`, for the downstream Manchester encoder.

---
 rtl/mvb_frame_tx_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mvb_frame_tx_seq.sv
// MVB transmit frame sequencer: serialises one data word MSB-first, runs the shared CRC unit and appends its 8 check bits.
// Optional build macro MVB_TX_FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module mvb_frame_tx_seq #(
    parameter int MAX_BITS = 64
) (
    input  logic                clk_1d5M,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] in_data,
    input  logic [1:0]          in_len,
    input  logic                abort,
    output logic                crc_ready,
    output logic                crc_send,
    output logic                crc_data,
    input  logic                crc_bit,
    output logic                tx_o,
    output logic                tx_valid,
    output logic                done,
    output logic                len_err
`ifdef MVB_TX_FRAME_CNT_EN
    ,
    output logic [15:0]         frame_cnt
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for a frame word, in_ready high
    // S_DATA  | data bits on crc_data, one per cycle, counter counts N-1 down to 0
    // S_CHECK | CRC unit shifts out its 8 check bits, counter counts 7 down to 0
    // S_TAIL  | crc_ready low for one cycle to clear the CRC unit
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK, S_TAIL} state_t;
    typedef enum logic [1:0] {PH_NONE, PH_DATA, PH_CHECK} phase_t;

    localparam logic [6:0] MAX_M1 = 7'(MAX_BITS - 1);

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [MAX_BITS-1:0] shreg_q, shreg_d;
    logic                in_ready_q, in_ready_d;
    logic                crc_ready_q, crc_ready_d;
    logic                crc_send_q, crc_send_d;
    logic                crc_data_q, crc_data_d;
    logic                tx_q, tx_d;
    logic                tx_valid_q, tx_valid_d;
    logic                done_q, done_d;
    logic                len_err_q, len_err_d;

    logic [6:0]          req_m1;
    logic [6:0]          len_m1;
    logic                len_bad;

    always_comb begin
        req_m1 = 7'd63;
        case (in_len)
            2'b00:   req_m1 = 7'd15;
            2'b01:   req_m1 = 7'd31;
            default: req_m1 = 7'd63;
        endcase
        // Illegal or too-long requests fall back to the widest field this build supports.
        len_bad = (in_len == 2'b11) || (req_m1 > MAX_M1);
        len_m1  = len_bad ? MAX_M1 : req_m1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        crc_data_d = 1'b0;
        crc_send_d = 1'b0;
        done_d     = 1'b0;
        len_err_d  = 1'b0;
        tx_d       = crc_data_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = S_DATA;
                    crc_data_d = in_data[MAX_BITS-1];
                    shreg_d    = in_data << 1;
                    cnt_d      = len_m1;
                    len_err_d  = len_bad;
                end
            end
            S_DATA: begin
                if (cnt_q == 7'd0) begin
                    state_d    = S_CHECK;
                    cnt_d      = 7'd7;
                    crc_send_d = 1'b1;
                end else begin
                    crc_data_d = shreg_q[MAX_BITS-1];
                    shreg_d    = shreg_q << 1;
                    cnt_d      = cnt_q - 7'd1;
                end
            end
            S_CHECK: begin
                if (cnt_q == 7'd0) begin
                    state_d = S_TAIL;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q - 7'd1;
                    crc_send_d = 1'b1;
                end
            end
            S_TAIL: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_TAIL;
            crc_data_d = 1'b0;
            crc_send_d = 1'b0;
            done_d     = 1'b0;
        end

        in_ready_d  = (state_d == S_IDLE);
        crc_ready_d = (state_d != S_TAIL);

        // Phase flag lags the state by one cycle so it lines up with tx_q and crc_bit.
        phase_d = PH_NONE;
        if (!(abort && (state_q != S_IDLE))) begin
            if (state_q == S_DATA)  phase_d = PH_DATA;
            if (state_q == S_CHECK) phase_d = PH_CHECK;
        end
        tx_valid_d = (phase_d != PH_NONE);
    end

    always_ff @(posedge clk_1d5M or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_NONE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            in_ready_q  <= 1'b0;
            crc_ready_q <= 1'b0;
            crc_send_q  <= 1'b0;
            crc_data_q  <= 1'b0;
            tx_q        <= 1'b0;
            tx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            in_ready_q  <= in_ready_d;
            crc_ready_q <= crc_ready_d;
            crc_send_q  <= crc_send_d;
            crc_data_q  <= crc_data_d;
            tx_q        <= tx_d;
            tx_valid_q  <= tx_valid_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign crc_ready = crc_ready_q;
    assign crc_send  = crc_send_q;
    assign crc_data  = crc_data_q;
    assign tx_valid  = tx_valid_q;
    assign done      = done_q;
    assign len_err   = len_err_q;
    assign tx_o      = (phase_q == PH_DATA)  ? tx_q    :
                       (phase_q == PH_CHECK) ? crc_bit : 1'b0;

`ifdef MVB_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_cnt_q + 16'(done_d);

    always_ff @(posedge clk_1d5M or negedge rst) begin
        if (!rst) frame_cnt_q <= '0;
        else      frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
